hex_digit_scanner: RTL and testbench

//  Time-multiplexes NUM_DIGITS 4-bit hex digits onto one shared seven-segment decoder.

---
 rtl/hex_disp_pkg.sv | 8 +
 rtl/hex_digit_scanner_tick_gen.sv | 27 ++
 rtl/hex_digit_scanner.sv | 80 ++++++++
 tb/tb_hex_digit_scanner.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants for the multiplexed hex display path (scanner and decoder wrapper).
package hex_disp_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic        ANODE_ON  = 1'b0;
  localparam logic [6:0]  BLANK_SEG = 7'b1111111;

endpackage

// File: rtl/hex_digit_scanner_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks.
module tick_gen #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned     CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared seven-segment decoder,
// with a frame-aligned double buffer and optional leading-zero blanking.
module hex_digit_scanner
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  input  logic                          value_valid,
  output logic                          value_ready,
  input  logic                          blank_lz_en,
  output logic [DIGIT_W-1:0]            hex_digit,
  output logic                          digit_blank,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_done
);

  localparam int unsigned      VAL_W    = DIGIT_W * NUM_DIGITS;
  localparam int unsigned      IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic             tick;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [VAL_W-1:0] disp_reg;
  logic [VAL_W-1:0] pend_reg;
  logic             pend_full;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign frame_done = tick && (idx == IDX_LAST);
  assign accept     = value_valid && value_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      disp_reg    <= '0;
      pend_reg    <= '0;
      pend_full   <= 1'b0;
      value_ready <= 1'b0;
    end else begin
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      // accept only happens with the pending slot empty, so it never races the transfer
      if (accept) begin
        pend_reg  <= value;
        pend_full <= 1'b1;
      end else if (frame_done && pend_full) begin
        disp_reg  <= pend_reg;
        pend_full <= 1'b0;
      end
      value_ready <= !accept && (!pend_full || frame_done);
    end
  end

  // digit i is blanked when every nibble from i upward is zero
  always_comb begin
    hex_digit   = '0;
    digit_sel   = '1;
    digit_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        hex_digit    = disp_reg[i*DIGIT_W +: DIGIT_W];
        digit_sel[i] = ANODE_ON;
        digit_blank  = blank_lz_en && (i != 0) && ((disp_reg >> (DIGIT_W * i)) == '0);
      end
    end
  end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed, table-driven bench for hex_digit_scanner (NUM_DIGITS=4, PRESCALE=4).
module tb_hex_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        blank_lz_en;
  logic [3:0]  hex_digit;
  logic        digit_blank;
  logic [3:0]  digit_sel;
  logic        frame_done;

  hex_digit_scanner #(
    .NUM_DIGITS(4),
    .PRESCALE  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .blank_lz_en(blank_lz_en),
    .hex_digit  (hex_digit),
    .digit_blank(digit_blank),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release; inputs apply just after that edge
  typedef struct {
    int          cyc;
    logic        rst_n;
    logic        valid;
    logic [15:0] value;
    logic        blank_en;
    logic [3:0]  hex;
    logic [3:0]  sel;
    logic        blank;
    logic        ready;
    logic        fd;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;

  task automatic add(input int c, input logic r, input logic v, input logic [15:0] val,
                     input logic b, input logic [3:0] h, input logic [3:0] s,
                     input logic bl, input logic rd, input logic fd);
    vec_t e;
    e.cyc = c; e.rst_n = r; e.valid = v; e.value = val; e.blank_en = b;
    e.hex = h; e.sel = s; e.blank = bl; e.ready = rd; e.fd = fd;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  task automatic chk_all(input int c, input logic [3:0] h, input logic [3:0] s,
                         input logic bl, input logic rd, input logic fd);
    chk("hex_digit",   c, 16'(hex_digit),   16'(h));
    chk("digit_sel",   c, 16'(digit_sel),   16'(s));
    chk("digit_blank", c, 16'(digit_blank), 16'(bl));
    chk("value_ready", c, 16'(value_ready), 16'(rd));
    chk("frame_done",  c, 16'(frame_done),  16'(fd));
  endtask

  initial begin
    //  cyc rst v  value     b  hex    sel      bl rdy fd
    // reset release, first accept of 1234, transfer at frame end
    add(  0, 1, 1, 16'h1234, 0, 4'h0, 4'b1110, 0, 0, 0);
    add(  1, 1, 1, 16'h1234, 0, 4'h0, 4'b1110, 0, 1, 0);
    add(  2, 1, 0, 16'h1234, 0, 4'h0, 4'b1110, 0, 0, 0);
    add(  4, 1, 0, 16'h1234, 0, 4'h0, 4'b1101, 0, 0, 0);
    add( 15, 1, 0, 16'h1234, 0, 4'h0, 4'b0111, 0, 0, 1);
    // scan of 1234
    add( 16, 1, 0, 16'h1234, 0, 4'h4, 4'b1110, 0, 1, 0);
    add( 20, 1, 0, 16'h1234, 0, 4'h3, 4'b1101, 0, 1, 0);
    add( 24, 1, 0, 16'h1234, 0, 4'h2, 4'b1011, 0, 1, 0);
    add( 28, 1, 0, 16'h1234, 0, 4'h1, 4'b0111, 0, 1, 0);
    add( 31, 1, 0, 16'h1234, 0, 4'h1, 4'b0111, 0, 1, 1);
    add( 32, 1, 0, 16'h1234, 0, 4'h4, 4'b1110, 0, 1, 0);
    // ABCD sent mid-frame at idx 1
    add( 36, 1, 1, 16'hABCD, 0, 4'h3, 4'b1101, 0, 1, 0);
    add( 37, 1, 0, 16'hABCD, 0, 4'h3, 4'b1101, 0, 0, 0);
    add( 40, 1, 0, 16'hABCD, 0, 4'h2, 4'b1011, 0, 0, 0);
    add( 44, 1, 0, 16'hABCD, 0, 4'h1, 4'b0111, 0, 0, 0);
    add( 47, 1, 0, 16'hABCD, 0, 4'h1, 4'b0111, 0, 0, 1);
    add( 48, 1, 0, 16'hABCD, 0, 4'hD, 4'b1110, 0, 1, 0);
    add( 52, 1, 0, 16'hABCD, 0, 4'hC, 4'b1101, 0, 1, 0);
    add( 56, 1, 0, 16'hABCD, 0, 4'hB, 4'b1011, 0, 1, 0);
    add( 60, 1, 0, 16'hABCD, 0, 4'hA, 4'b0111, 0, 1, 0);
    // backpressure: 0F0F fills the pending slot, 5555 held until ready returns
    add( 61, 1, 1, 16'h0F0F, 0, 4'hA, 4'b0111, 0, 1, 0);
    add( 62, 1, 1, 16'h5555, 0, 4'hA, 4'b0111, 0, 0, 0);
    add( 63, 1, 1, 16'h5555, 0, 4'hA, 4'b0111, 0, 0, 1);
    add( 64, 1, 1, 16'h5555, 0, 4'hF, 4'b1110, 0, 1, 0);
    add( 65, 1, 0, 16'h5555, 0, 4'hF, 4'b1110, 0, 0, 0);
    add( 68, 1, 0, 16'h5555, 0, 4'h0, 4'b1101, 0, 0, 0);
    add( 79, 1, 0, 16'h5555, 0, 4'h0, 4'b0111, 0, 0, 1);
    add( 80, 1, 0, 16'h5555, 0, 4'h5, 4'b1110, 0, 1, 0);
    // accept coincident with frame_done is shown one frame later
    add( 95, 1, 1, 16'h0050, 0, 4'h5, 4'b0111, 0, 1, 1);
    add( 96, 1, 0, 16'h0050, 0, 4'h5, 4'b1110, 0, 0, 0);
    add(111, 1, 0, 16'h0050, 0, 4'h5, 4'b0111, 0, 0, 1);
    // leading-zero blanking of 0050
    add(112, 1, 0, 16'h0050, 1, 4'h0, 4'b1110, 0, 1, 0);
    add(116, 1, 0, 16'h0050, 1, 4'h5, 4'b1101, 0, 1, 0);
    add(120, 1, 0, 16'h0050, 1, 4'h0, 4'b1011, 1, 1, 0);
    add(124, 1, 0, 16'h0050, 1, 4'h0, 4'b0111, 1, 1, 0);
    // all-zero value: digit 0 never blanked
    add(125, 1, 1, 16'h0000, 1, 4'h0, 4'b0111, 1, 1, 0);
    add(126, 1, 0, 16'h0000, 1, 4'h0, 4'b0111, 1, 0, 0);
    add(127, 1, 0, 16'h0000, 1, 4'h0, 4'b0111, 1, 0, 1);
    add(128, 1, 0, 16'h0000, 1, 4'h0, 4'b1110, 0, 1, 0);
    add(132, 1, 0, 16'h0000, 1, 4'h0, 4'b1101, 1, 1, 0);
    add(136, 1, 0, 16'h0000, 1, 4'h0, 4'b1011, 1, 1, 0);
    add(140, 1, 0, 16'h0000, 1, 4'h0, 4'b0111, 1, 1, 0);
    add(141, 1, 0, 16'h0000, 0, 4'h0, 4'b0111, 0, 1, 0);
    add(144, 1, 0, 16'h0000, 0, 4'h0, 4'b1110, 0, 1, 0);
    add(148, 1, 0, 16'h0000, 0, 4'h0, 4'b1101, 0, 1, 0);
    // mid-operation reset with a pending 1234
    add(149, 1, 1, 16'h1234, 0, 4'h0, 4'b1101, 0, 1, 0);
    add(150, 1, 0, 16'h1234, 0, 4'h0, 4'b1101, 0, 0, 0);
    add(152, 1, 0, 16'h1234, 0, 4'h0, 4'b1011, 0, 0, 0);
    add(153, 0, 0, 16'h1234, 0, 4'h0, 4'b1110, 0, 0, 0);
    add(154, 0, 0, 16'h1234, 0, 4'h0, 4'b1110, 0, 0, 0);
    add(156, 1, 0, 16'h1234, 0, 4'h0, 4'b1110, 0, 0, 0);
    add(157, 1, 0, 16'h1234, 0, 4'h0, 4'b1110, 0, 1, 0);
    add(171, 1, 0, 16'h1234, 0, 4'h0, 4'b0111, 0, 1, 1);
    add(172, 1, 0, 16'h1234, 0, 4'h0, 4'b1110, 0, 1, 0);
    add(176, 1, 0, 16'h1234, 0, 4'h0, 4'b1101, 0, 1, 0);

    rst_n       = 1'b0;
    value_valid = 1'b0;
    value       = '0;
    blank_lz_en = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all(-1, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    cyc = 0;
    foreach (vecs[k]) begin
      while (cyc < vecs[k].cyc) begin
        @(posedge clk);
        cyc++;
      end
      #1;
      rst_n       = vecs[k].rst_n;
      value_valid = vecs[k].valid;
      value       = vecs[k].value;
      blank_lz_en = vecs[k].blank_en;
      @(negedge clk);
      chk_all(cyc, vecs[k].hex, vecs[k].sel, vecs[k].blank, vecs[k].ready, vecs[k].fd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
